// File: rtl/score_keeper.sv
// score_keeper: credits, lives, BCD score and high score for a shooter game
module score_keeper #(
  parameter int START_LIVES  = 3,
  parameter int MAX_CREDITS  = 9,
  parameter int DYING_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [7:0]  scoreUpdate,
  input  logic        playerHit,
  input  logic        keyCoinN,
  input  logic        startGame,
  input  logic        standBy,
  input  logic        gameEnded,
  output logic [3:0]  credits,
  output logic [2:0]  lives,
  output logic        gameLose,
  output logic [15:0] score,
  output logic [15:0] highScore,
  output logic        newHighScore,
  output logic        playerHitPulse
);
  typedef enum logic [1:0] {sIdle, sPlaying, sDying, sLost} state_t;
  state_t state_q, state_d;
  logic [3:0]  credits_q, credits_d;
  logic [2:0]  lives_q, lives_d;
  logic        lose_q, lose_d;
  logic [15:0] score_q, score_d;
  logic [15:0] high_q, high_d;
  logic        newhigh_q, newhigh_d;
  logic        pulse_q, pulse_d;
  logic [9:0]  pend_q, pend_d;
  logic        flag_q, flag_d;
  logic [7:0]  frames_q, frames_d;
  logic [2:0]  sync_q;
  logic        start_prev_q, hit_prev_q;
  logic        coin_fall, start_ok, accept, drain, beats;
  logic [7:0]  add;
  logic [10:0] pend_sum;
  logic [4:0]  cred_sum;
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++)
      if (c) begin
        if (r[i*4+:4] == 4'd9) r[i*4+:4] = 4'd0;
        else begin
          r[i*4+:4] = r[i*4+:4] + 4'd1;
          c = 1'b0;
        end
      end
    return v == 16'h9999 ? v : r;
  endfunction
  assign credits        = credits_q;
  assign lives          = lives_q;
  assign gameLose       = lose_q;
  assign score          = score_q;
  assign highScore      = high_q;
  assign newHighScore   = newhigh_q;
  assign playerHitPulse = pulse_q;
  // next-state: game FSM, credit/pending arithmetic, score drain and high-score tracking
  always_comb begin
    coin_fall = sync_q[2] & ~sync_q[1];
    start_ok  = startGame & ~start_prev_q & (credits_q != 4'd0) & (state_q == sIdle || state_q == sLost);
    accept    = (state_q == sPlaying) & playerHit & ~hit_prev_q & ~flag_q;
    drain     = pend_q != 10'd0;
    beats     = higher(score_q, high_q);
    add       = (state_q == sPlaying || state_q == sDying) ? scoreUpdate : 8'd0;
    pend_sum  = 11'(pend_q) + 11'(add) - 11'(drain);
    cred_sum  = 5'(credits_q) + 5'(coin_fall) - 5'(start_ok);
    credits_d = cred_sum > 5'(MAX_CREDITS) ? 4'(MAX_CREDITS) : cred_sum[3:0];
    score_d   = start_ok ? 16'h0 : drain ? bcd_inc(score_q) : score_q;
    pend_d    = start_ok ? 10'd0 : pend_sum > 11'd1023 ? 10'h3ff : pend_sum[9:0];
    high_d    = beats ? score_q : high_q;
    newhigh_d = ~start_ok & (beats | newhigh_q);
    flag_d    = accept | (flag_q & ~startOfFrame);
    pulse_d   = accept;
    state_d   = state_q;
    lives_d   = lives_q;
    lose_d    = lose_q;
    frames_d  = frames_q;
    unique case (state_q)
      sIdle: if (start_ok) begin
        state_d = sPlaying;
        lives_d = 3'(START_LIVES);
      end
      sPlaying: if (accept) begin
        lives_d  = lives_q - 3'd1;
        frames_d = 8'd0;
        lose_d   = lives_q == 3'd1;
        state_d  = lives_q == 3'd1 ? sLost : sDying;
      end
      sDying: if (startOfFrame) begin
        frames_d = frames_q == 8'(DYING_FRAMES - 1) ? 8'd0 : frames_q + 8'd1;
        state_d  = frames_q == 8'(DYING_FRAMES - 1) ? sPlaying : sDying;
      end
      sLost: if (start_ok) begin
        state_d = sPlaying;
        lives_d = 3'(START_LIVES);
        lose_d  = 1'b0;
      end else if (standBy & ~gameEnded) begin
        state_d = sIdle;
        lose_d  = 1'b0;
      end
    endcase
  end
  // BCD digits are ordered like binary, so a plain magnitude compare is a BCD compare
  function automatic logic higher(input logic [15:0] a, input logic [15:0] b);
    return a > b;
  endfunction
  // state registers, coin synchronizer and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= sIdle;
      credits_q    <= 4'd0;
      lives_q      <= 3'd0;
      lose_q       <= 1'b0;
      score_q      <= 16'h0;
      high_q       <= 16'h0;
      newhigh_q    <= 1'b0;
      pulse_q      <= 1'b0;
      pend_q       <= 10'd0;
      flag_q       <= 1'b0;
      frames_q     <= 8'd0;
      sync_q       <= 3'b111;
      start_prev_q <= 1'b0;
      hit_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      lives_q      <= lives_d;
      lose_q       <= lose_d;
      score_q      <= score_d;
      high_q       <= high_d;
      newhigh_q    <= newhigh_d;
      pulse_q      <= pulse_d;
      pend_q       <= pend_d;
      flag_q       <= flag_d;
      frames_q     <= frames_d;
      sync_q       <= {sync_q[1:0], keyCoinN};
      start_prev_q <= startGame;
      hit_prev_q   <= playerHit;
    end
  end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboarded random and directed test of score_keeper
module tb_score_keeper;
  localparam int START = 3;
  localparam int MAXC  = 9;
  localparam int DF    = 60;
  localparam int IDLE = 0, PLAY = 1, DYING = 2, LOST = 3;
  logic clk = 0, reset = 1, startOfFrame = 0, playerHit = 0, keyCoinN = 1;
  logic startGame = 0, standBy = 0, gameEnded = 0, sof_en = 1;
  logic [7:0] scoreUpdate = 0;
  logic [3:0] credits;
  logic [2:0] lives;
  logic gameLose, newHighScore, playerHitPulse;
  logic [15:0] score, highScore;
  int checks = 0, errors = 0, pulses = 0, cyc = 0;
  logic [41:0] expq[$];
  int m_mode, m_cred, m_lives, m_lose, m_score, m_high, m_nh, m_pulse, m_pend, m_flag, m_frames;
  int c1, c2, c3, m_ps, m_ph;
  score_keeper #(.START_LIVES(START), .MAX_CREDITS(MAXC), .DYING_FRAMES(DF)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .scoreUpdate(scoreUpdate),
    .playerHit(playerHit), .keyCoinN(keyCoinN), .startGame(startGame), .standBy(standBy),
    .gameEnded(gameEnded), .credits(credits), .lives(lives), .gameLose(gameLose),
    .score(score), .highScore(highScore), .newHighScore(newHighScore),
    .playerHitPulse(playerHitPulse)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic logic [7:0] pick();
    int k;
    k = $urandom_range(0, 3);
    return k == 0 ? 8'd10 : k == 1 ? 8'd20 : k == 2 ? 8'd30 : 8'd100;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic coin();
    keyCoinN = 0;
    tick(3);
    keyCoinN = 1;
    tick(3);
  endtask
  task automatic award(input logic [7:0] v);
    scoreUpdate = v;
    tick(1);
    scoreUpdate = 0;
  endtask
  task automatic model_step();
    int coin_f, start_ok, acc, drain, add, ncred, nscore, npend;
    if (reset) begin
      m_mode = IDLE; m_cred = 0; m_lives = 0; m_lose = 0; m_score = 0; m_high = 0;
      m_nh = 0; m_pulse = 0; m_pend = 0; m_flag = 0; m_frames = 0;
      c1 = 1; c2 = 1; c3 = 1; m_ps = 0; m_ph = 0;
    end else begin
      coin_f   = (c3 == 1 && c2 == 0);
      start_ok = startGame && !m_ps && m_cred > 0 && (m_mode == IDLE || m_mode == LOST);
      acc      = m_mode == PLAY && playerHit && !m_ph && !m_flag;
      drain    = m_pend > 0;
      add      = (m_mode == PLAY || m_mode == DYING) ? int'(scoreUpdate) : 0;
      ncred    = m_cred + coin_f - start_ok;
      if (ncred > MAXC) ncred = MAXC;
      nscore   = drain ? (m_score < 9999 ? m_score + 1 : 9999) : m_score;
      npend    = m_pend + add - drain;
      if (npend > 1023) npend = 1023;
      if (m_score > m_high) begin
        m_high = m_score;
        m_nh = 1;
      end
      if (start_ok) begin
        nscore = 0; npend = 0; m_nh = 0;
      end
      m_pulse = acc;
      m_flag  = acc || (m_flag && !startOfFrame);
      case (m_mode)
        IDLE: if (start_ok) begin m_mode = PLAY; m_lives = START; end
        PLAY: if (acc) begin
          m_lives--;
          if (m_lives == 0) begin m_mode = LOST; m_lose = 1; end
          else begin m_mode = DYING; m_frames = 0; end
        end
        DYING: if (startOfFrame) begin
          m_frames++;
          if (m_frames == DF) m_mode = PLAY;
        end
        default: if (start_ok) begin
          m_mode = PLAY; m_lives = START; m_lose = 0;
        end else if (standBy && !gameEnded) begin
          m_mode = IDLE; m_lose = 0;
        end
      endcase
      m_cred = ncred; m_score = nscore; m_pend = npend;
      c3 = c2; c2 = c1; c1 = keyCoinN; m_ps = startGame; m_ph = playerHit;
    end
    expq.push_back({4'(m_cred), 3'(m_lives), 1'(m_lose), bcd(m_score), bcd(m_high), 1'(m_nh), 1'(m_pulse)});
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    startOfFrame = sof_en && (cyc % 4 == 0);
  end
  initial forever begin
    logic [41:0] act, e;
    @(negedge clk);
    if (playerHitPulse === 1'b1) pulses++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      act = {credits, lives, gameLose, score, highScore, newHighScore, playerHitPulse};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle%0d actual cr=%0d lv=%0d lose=%0b sc=%h hi=%h nh=%0b pl=%0b required cr=%0d lv=%0d lose=%0b sc=%h hi=%h nh=%0b pl=%0b",
          cyc, act[41:38], act[37:35], act[34], act[33:18], act[17:2], act[1], act[0],
          e[41:38], e[37:35], e[34], e[33:18], e[17:2], e[1], e[0]);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int p0;
    tick(3);
    reset = 0;
    chk("reset_credits", 32'(credits), 0);
    chk("reset_lives", 32'(lives), 0);
    chk("reset_score", 32'(score), 0);
    coin();
    coin();
    chk("two_coins", 32'(credits), 2);
    startGame = 1;
    tick(2);
    chk("start_credit", 32'(credits), 1);
    chk("start_lives", 32'(lives), 3);
    startGame = 0;
    tick(2);
    award(100);
    tick(9);
    award(30);
    tick(119);
    chk("score_0129", 32'(score), 32'h0129);
    tick(1);
    chk("score_0130", 32'(score), 32'h0130);
    tick(1);
    chk("high_0130", 32'(highScore), 32'h0130);
    chk("new_high", 32'(newHighScore), 1);
    p0 = pulses;
    playerHit = 1;
    tick(14);
    chk("one_pulse", 32'(pulses - p0), 1);
    chk("lives_2", 32'(lives), 2);
    playerHit = 0;
    tick(2);
    playerHit = 1;
    tick(2);
    playerHit = 0;
    chk("dying_ignores", 32'(lives), 2);
    tick(240);
    playerHit = 1;
    tick(2);
    playerHit = 0;
    tick(2);
    chk("lives_1", 32'(lives), 1);
    tick(250);
    playerHit = 1;
    tick(1);
    chk("lose_set", 32'(gameLose), 1);
    chk("lives_0", 32'(lives), 0);
    playerHit = 0;
    gameEnded = 1;
    tick(3);
    chk("lose_held", 32'(gameLose), 1);
    standBy = 1;
    gameEnded = 0;
    tick(2);
    chk("lose_clear", 32'(gameLose), 0);
    standBy = 0;
    repeat (8) coin();
    chk("credits_9", 32'(credits), 9);
    coin();
    chk("credits_sat", 32'(credits), 9);
    for (int i = 0; i < 3000; i++) begin
      scoreUpdate = ($urandom_range(0, 11) == 0) ? pick() : 8'd0;
      if ($urandom_range(0, 15) == 0) playerHit = ~playerHit;
      if ($urandom_range(0, 40) == 0) keyCoinN = ~keyCoinN;
      if ($urandom_range(0, 30) == 0) startGame = ~startGame;
      standBy = $urandom_range(0, 20) == 0;
      gameEnded = $urandom_range(0, 3) == 0;
      tick(1);
    end
    scoreUpdate = 0; playerHit = 0; keyCoinN = 1; startGame = 0; standBy = 0; gameEnded = 0;
    tick(5);
    reset = 1;
    tick(1);
    reset = 0;
    coin();
    startGame = 1;
    tick(1);
    startGame = 0;
    tick(1);
    award(100);
    tick(20);
    chk("mid_score", 32'(score), 32'h0020);
    reset = 1;
    tick(1);
    reset = 0;
    chk("rst_score", 32'(score), 0);
    chk("rst_high", 32'(highScore), 0);
    chk("rst_credits", 32'(credits), 0);
    tick(5);
    chk("rst_no_drain", 32'(score), 0);
    startGame = 1;
    tick(3);
    chk("nocredit_lives", 32'(lives), 0);
    chk("nocredit_credits", 32'(credits), 0);
    startGame = 0;
    tick(1);
    repeat (3) coin();
    chk("credits_3", 32'(credits), 3);
    keyCoinN = 0;
    tick(2);
    startGame = 1;
    tick(1);
    chk("coin_and_start", 32'(credits), 3);
    chk("coin_start_lives", 32'(lives), 3);
    keyCoinN = 1;
    startGame = 0;
    tick(4);
    chk("coin_start_after", 32'(credits), 3);
    repeat (99) begin
      award(100);
      tick(100);
    end
    repeat (3) begin
      award(30);
      tick(30);
    end
    chk("score_9990", 32'(score), 32'h9990);
    award(10);
    tick(10);
    chk("score_sat", 32'(score), 32'h9999);
    tick(2);
    chk("high_sat", 32'(highScore), 32'h9999);
    tick(5);
    chk("score_stays", 32'(score), 32'h9999);
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
